// File: rtl/ram_program_loader.sv
// Program loader: synchronizes an external byte strobe and writes 16 bytes into program RAM
// while holding the CPU in reset. Define LOADER_CHECKSUM_EN to add a running 8-bit byte sum.
module ram_program_loader #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 8,
   parameter int RAM_BYTES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [DATA_W-1:0] byte_in,
   input  logic              byte_strobe,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_we,
   output logic              cpu_hold,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic [7:0]        checksum
);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

   state_t            state_q;
   logic              sync1_q, sync2_q, sync3_q;
   logic              strobeEdge;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_data_q;
   logic              ram_we_q;
   logic              cpu_hold_q;
   logic              done_q;
   logic [ADDR_W:0]   count_q;

   // The strobe pin is asynchronous: two flops for metastability, a third to find the rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= byte_strobe;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign strobeEdge = sync2_q & ~sync3_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         ram_we_q   <= 1'b0;
         cpu_hold_q <= 1'b0;
         done_q     <= 1'b0;
         count_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               ram_we_q   <= 1'b0;
               cpu_hold_q <= 1'b0;
               done_q     <= 1'b0;
               if (load_en) begin
                  state_q    <= LOAD;
                  ptr_q      <= '0;
                  count_q    <= '0;
                  cpu_hold_q <= 1'b1;
               end
            end
            LOAD: begin
               // An abort wins over a strobe edge arriving in the same cycle.
               if (!load_en) begin
                  state_q    <= IDLE;
                  cpu_hold_q <= 1'b0;
               end else if (strobeEdge) begin
                  state_q    <= WRITE;
                  ram_addr_q <= ptr_q;
                  ram_data_q <= byte_in;
                  ram_we_q   <= 1'b1;
               end
            end
            WRITE: begin
               ram_we_q <= 1'b0;
               count_q  <= count_q + (ADDR_W+1)'(1);
               // The pointer parks on the last address rather than wrapping.
               if (ptr_q != LAST_ADDR) begin
                  ptr_q <= ptr_q + ADDR_W'(1);
               end
               if (!load_en) begin
                  state_q    <= IDLE;
                  cpu_hold_q <= 1'b0;
               end else if (ptr_q == LAST_ADDR) begin
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  cpu_hold_q <= 1'b0;
               end else begin
                  state_q <= LOAD;
               end
            end
            DONE: begin
               if (!load_en) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] checksum_q;

   // Sum restarts with each new session and adds the byte being written in the WRITE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         checksum_q <= '0;
      end else if (state_q == IDLE && load_en) begin
         checksum_q <= '0;
      end else if (state_q == WRITE) begin
         checksum_q <= checksum_q + 8'(ram_data_q);
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 8'h00;
`endif

   assign ram_addr = ram_addr_q;
   assign ram_data = ram_data_q;
   assign ram_we   = ram_we_q;
   assign cpu_hold = cpu_hold_q;
   assign done     = done_q;
   assign count    = count_q;

endmodule

// File: tb/tb_ram_program_loader.sv
// Directed bench for ram_program_loader: reset, full load, latency, abort, drop in WRITE, reset mid-load.
module tb_ram_program_loader;

   logic       clk;
   logic       rst;
   logic       loadEn;
   logic [7:0] byteIn;
   logic       byteStrobe;
   logic [3:0] ramAddr;
   logic [7:0] ramData;
   logic       ramWe;
   logic       cpuHold;
   logic       done;
   logic [4:0] count;
   logic [7:0] checksum;

   int passCount  = 0;
   int checkCount = 0;

`ifdef LOADER_CHECKSUM_EN
   localparam logic [7:0] FULL_SUM = 8'h78;
`else
   localparam logic [7:0] FULL_SUM = 8'h00;
`endif

   ram_program_loader #(.ADDR_W(4), .DATA_W(8), .RAM_BYTES(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_en    (loadEn),
      .byte_in    (byteIn),
      .byte_strobe(byteStrobe),
      .ram_addr   (ramAddr),
      .ram_data   (ramData),
      .ram_we     (ramWe),
      .cpu_hold   (cpuHold),
      .done       (done),
      .count      (count),
      .checksum   (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " addr"}, 32'(ramAddr), 0);
      checkOutput({tag, " data"}, 32'(ramData), 0);
      checkOutput({tag, " we"}, 32'(ramWe), 0);
      checkOutput({tag, " hold"}, 32'(cpuHold), 0);
      checkOutput({tag, " done"}, 32'(done), 0);
      checkOutput({tag, " count"}, 32'(count), 0);
      checkOutput({tag, " checksum"}, 32'(checksum), 0);
   endtask

   // One byte: strobe high 4 cycles then low 4; the write pulse lands on the third edge.
   task automatic applyStimulus(input logic [7:0] value, input logic [3:0] expAddr, input int expCount);
      byteIn     = value;
      byteStrobe = 1'b1;
      tick();
      tick();
      checkOutput("pre-write we", 32'(ramWe), 0);
      tick();
      checkOutput("write we", 32'(ramWe), 1);
      checkOutput("write addr", 32'(ramAddr), 32'(expAddr));
      checkOutput("write data", 32'(ramData), 32'(value));
      checkOutput("write hold", 32'(cpuHold), 1);
      tick();
      checkOutput("post-write we", 32'(ramWe), 0);
      checkOutput("post-write count", 32'(count), 32'(expCount));
      byteStrobe = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      int weSeen;
      rst        = 1'b1;
      loadEn     = 1'b0;
      byteIn     = 8'h00;
      byteStrobe = 1'b0;
      repeat (2) tick();
      checkAllZero("reset");
      rst = 1'b0;

      // Strobes while idle must never write.
      weSeen = 0;
      for (int i = 0; i < 24; i++) begin
         byteStrobe = ((i / 4) % 2) == 0;
         byteIn     = 8'(i);
         tick();
         if (ramWe) weSeen++;
      end
      byteStrobe = 1'b0;
      checkOutput("idle no writes", 32'(weSeen), 0);
      checkOutput("idle hold", 32'(cpuHold), 0);

      // Full 16-byte image.
      loadEn = 1'b1;
      tick();
      checkOutput("load hold", 32'(cpuHold), 1);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(8'h10 + 8'(i), 4'(i), i + 1);
         if (i < 15) checkOutput("mid-load done", 32'(done), 0);
      end
      checkOutput("full done", 32'(done), 1);
      checkOutput("full hold", 32'(cpuHold), 0);
      checkOutput("full count", 32'(count), 16);
      checkOutput("full checksum", 32'(checksum), 32'(FULL_SUM));

      // Strobe in DONE is ignored.
      weSeen     = 0;
      byteStrobe = 1'b1;
      repeat (4) begin tick(); if (ramWe) weSeen++; end
      byteStrobe = 1'b0;
      repeat (4) begin tick(); if (ramWe) weSeen++; end
      checkOutput("done ignores strobe", 32'(weSeen), 0);
      checkOutput("done count held", 32'(count), 16);
      checkOutput("done still high", 32'(done), 1);

      // Leave DONE, re-enter, then a strobe held for 20 cycles gives one write at edge k+2.
      loadEn = 1'b0;
      tick();
      checkOutput("exit done", 32'(done), 0);
      loadEn = 1'b1;
      tick();
      byteIn     = 8'hC3;
      byteStrobe = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checkOutput("held strobe we", 32'(ramWe), (i == 2) ? 32'd1 : 32'd0);
         if (i == 2) begin
            checkOutput("held addr", 32'(ramAddr), 0);
            checkOutput("held data", 32'(ramData), 32'hC3);
         end
      end
      byteStrobe = 1'b0;
      repeat (4) tick();
      checkOutput("held count", 32'(count), 1);

      // Abort after 5 bytes, then restart at address 0.
      loadEn = 1'b0;
      tick();
      loadEn = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) applyStimulus(8'hA0 + 8'(i), 4'(i), i + 1);
      loadEn = 1'b0;
      tick();
      checkOutput("abort hold", 32'(cpuHold), 0);
      checkOutput("abort done", 32'(done), 0);
      checkOutput("abort count", 32'(count), 5);
      loadEn = 1'b1;
      tick();
      applyStimulus(8'h55, 4'd0, 1);

      // load_en drops during the WRITE cycle of byte 3.
      loadEn = 1'b0;
      tick();
      loadEn = 1'b1;
      tick();
      applyStimulus(8'h61, 4'd0, 1);
      applyStimulus(8'h62, 4'd1, 2);
      byteIn     = 8'h63;
      byteStrobe = 1'b1;
      tick();
      tick();
      tick();
      checkOutput("drop write we", 32'(ramWe), 1);
      checkOutput("drop write addr", 32'(ramAddr), 2);
      loadEn = 1'b0;
      tick();
      checkOutput("drop we", 32'(ramWe), 0);
      checkOutput("drop count", 32'(count), 3);
      checkOutput("drop hold", 32'(cpuHold), 0);
      checkOutput("drop done", 32'(done), 0);
      byteStrobe = 1'b0;
      repeat (4) tick();
      checkOutput("drop stays idle", 32'(cpuHold), 0);

      // Reset after 7 bytes, then a full reload from address 0.
      loadEn = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) applyStimulus(8'h30 + 8'(i), 4'(i), i + 1);
      rst = 1'b1;
      tick();
      checkAllZero("mid reset");
      rst = 1'b0;
      tick();
      checkOutput("reload hold", 32'(cpuHold), 1);
      for (int i = 0; i < 16; i++) applyStimulus(8'h10 + 8'(i), 4'(i), i + 1);
      checkOutput("reload done", 32'(done), 1);
      checkOutput("reload count", 32'(count), 16);
      checkOutput("reload checksum", 32'(checksum), 32'(FULL_SUM));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
